// File: rtl/fc_pkg.sv
// Shared types and width helpers for the folded binary fully-connected layer.
//   state_e  : sequencer states
//   fold_w   : fold address width, at least 1 bit
//   pop_n    : largest popcount a neuron can produce
//   result_w : bits needed to hold a popcount or threshold
package fc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  function automatic int unsigned fold_w(int unsigned fold);
    return (fold > 1) ? $clog2(fold) : 1;
  endfunction

  function automatic int unsigned pop_n(int unsigned majority, int unsigned ch_in);
    return (majority != 0) ? ch_in / 3 : ch_in;
  endfunction

  function automatic int unsigned result_w(int unsigned pop_max);
    return $clog2(pop_max + 1);
  endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Bus bundle for fc_layer_seq: weight/threshold loader ports, activation input
// handshake, result output handshake and busy flag.
//   master : loader/producer/consumer side (testbench or upstream logic)
//   slave  : the layer itself
interface fc_layer_seq_if #(
  parameter int unsigned MAJORITY = 0,
  parameter int unsigned FOLD     = 4,
  parameter int unsigned CH_IN    = 12,
  parameter int unsigned CH_OUT   = 8
);
  import fc_pkg::*;

  localparam int unsigned CH_OUT_FOLD = CH_OUT / FOLD;
  localparam int unsigned FOLD_W      = fold_w(FOLD);
  localparam int unsigned RESULT_W    = result_w(pop_n(MAJORITY, CH_IN));

  logic                            wt_we;
  logic [FOLD_W-1:0]               wt_addr;
  logic [CH_IN*CH_OUT_FOLD-1:0]    wt_data;
  logic                            th_we;
  logic [FOLD_W-1:0]               th_addr;
  logic [RESULT_W*CH_OUT_FOLD-1:0] th_data;
  logic                            in_valid;
  logic                            in_ready;
  logic [CH_IN-1:0]                in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [CH_OUT-1:0]               out_data;
  logic [RESULT_W*CH_OUT-1:0]      out_pop;
  logic                            busy;

  modport master (
    output wt_we, wt_addr, wt_data, th_we, th_addr, th_data,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_pop, busy
  );

  modport slave (
    input  wt_we, wt_addr, wt_data, th_we, th_addr, th_data,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_pop, busy
  );

endinterface

// File: rtl/xnor_pop_pe.sv
// Binary neuron datapath: XNOR activation against weights, then popcount.
// With MAJORITY set, each group of three XNOR bits is first reduced by a
// 3-input majority vote and the group votes are counted instead.
//   a   : activation vector
//   w   : weight vector for this neuron
//   pop : unsigned popcount
module xnor_pop_pe
  import fc_pkg::*;
#(
  parameter int unsigned MAJORITY = 0,
  parameter int unsigned CH_IN    = 12,
  localparam int unsigned RESULT_W = result_w(pop_n(MAJORITY, CH_IN))
) (
  input  logic [CH_IN-1:0]    a,
  input  logic [CH_IN-1:0]    w,
  output logic [RESULT_W-1:0] pop
);

  logic [CH_IN-1:0] x;
  assign x = ~(a ^ w);

  if (MAJORITY != 0) begin : g_maj
    localparam int unsigned GROUPS = CH_IN / 3;
    always_comb begin
      pop = '0;
      for (int g = 0; g < GROUPS; g++) begin
        pop = pop + RESULT_W'((x[3*g] & x[3*g+1]) | (x[3*g] & x[3*g+2]) |
                              (x[3*g+1] & x[3*g+2]));
      end
    end
  end else begin : g_pop
    always_comb begin
      pop = '0;
      for (int i = 0; i < CH_IN; i++) begin
        pop = pop + RESULT_W'(x[i]);
      end
    end
  end

endmodule

// File: rtl/fc_layer_seq.sv
// Self-sequencing folded binary fully-connected layer. Latches one activation
// vector, sweeps all FOLD weight/threshold rows (CH_OUT/FOLD neurons per row),
// and presents CH_OUT thresholded bits plus raw popcounts until accepted.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : loader, input and output handshakes (fc_layer_seq_if.slave)
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int unsigned MAJORITY = 0,
  parameter int unsigned FOLD     = 4,
  parameter int unsigned CH_IN    = 12,
  parameter int unsigned CH_OUT   = 8
) (
  input logic           clk,
  input logic           reset,
  fc_layer_seq_if.slave bus
);

  localparam int unsigned CH_OUT_FOLD = CH_OUT / FOLD;
  localparam int unsigned FOLD_W      = fold_w(FOLD);
  localparam int unsigned RESULT_W    = result_w(pop_n(MAJORITY, CH_IN));
  localparam int unsigned WT_W        = CH_IN * CH_OUT_FOLD;
  localparam int unsigned TH_W        = RESULT_W * CH_OUT_FOLD;

  state_e                     state_q, state_d;
  logic [FOLD_W-1:0]          fold_cnt_q, fold_cnt_d;
  logic [CH_IN-1:0]           act_q, act_d;
  logic                       out_valid_q, out_valid_d;
  logic [CH_OUT-1:0]          out_data_q, out_data_d;
  logic [RESULT_W*CH_OUT-1:0] out_pop_q, out_pop_d;
  // Tag travelling with the registered memory read: which fold it belongs to.
  logic                       rd_valid_q;
  logic [FOLD_W-1:0]          rd_fold_q;

  logic [WT_W-1:0] wt_mem [FOLD];
  logic [TH_W-1:0] th_mem [FOLD];
  logic [WT_W-1:0] wt_rd_q;
  logic [TH_W-1:0] th_rd_q;
  logic            wt_addr_ok, th_addr_ok;

  // Drop writes to rows beyond FOLD when FOLD is not a power of two.
  assign wt_addr_ok = {1'b0, bus.wt_addr} < (FOLD_W+1)'(FOLD);
  assign th_addr_ok = {1'b0, bus.th_addr} < (FOLD_W+1)'(FOLD);

  // Storage is not reset; a collision returns the old row.
  always_ff @(posedge clk) begin
    if (bus.wt_we && wt_addr_ok) wt_mem[bus.wt_addr] <= bus.wt_data;
    if (bus.th_we && th_addr_ok) th_mem[bus.th_addr] <= bus.th_data;
    wt_rd_q <= wt_mem[fold_cnt_q];
    th_rd_q <= th_mem[fold_cnt_q];
  end

  logic [RESULT_W-1:0] pe_pop [CH_OUT_FOLD];

  for (genvar j = 0; j < CH_OUT_FOLD; j++) begin : g_pe
    xnor_pop_pe #(
      .MAJORITY(MAJORITY),
      .CH_IN   (CH_IN)
    ) u_pe (
      .a  (act_q),
      .w  (wt_rd_q[j*CH_IN +: CH_IN]),
      .pop(pe_pop[j])
    );
  end

  always_comb begin
    state_d     = state_q;
    fold_cnt_d  = fold_cnt_q;
    act_d       = act_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_pop_d   = out_pop_q;

    // Results land one cycle after the row read; only active in RUN/DRAIN.
    if (rd_valid_q) begin
      for (int j = 0; j < CH_OUT_FOLD; j++) begin
        out_data_d[int'(rd_fold_q)*CH_OUT_FOLD + j] =
            pe_pop[j] > th_rd_q[j*RESULT_W +: RESULT_W];
        out_pop_d[(int'(rd_fold_q)*CH_OUT_FOLD + j)*RESULT_W +: RESULT_W] = pe_pop[j];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = RUN;
          act_d      = bus.in_data;
          fold_cnt_d = '0;
          out_data_d = '0;
          out_pop_d  = '0;
        end
      end
      RUN: begin
        if (fold_cnt_q == FOLD_W'(FOLD - 1)) begin
          state_d = DRAIN;
        end else begin
          fold_cnt_d = fold_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fold_cnt_q  <= '0;
      act_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pop_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_fold_q   <= '0;
    end else begin
      state_q     <= state_d;
      fold_cnt_q  <= fold_cnt_d;
      act_q       <= act_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_pop_q   <= out_pop_d;
      rd_valid_q  <= (state_q == RUN);
      rd_fold_q   <= fold_cnt_q;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_pop   = out_pop_q;

endmodule
